// File: rtl/irq_encoder_8to3_pkg.sv
// ============================================================================
// irq_encoder_8to3_pkg
// Shared encoder/decoder definitions: code and one-hot widths, the 2-state
// presentation FSM encoding and a one-hot helper. Written so the 3-to-8
// decoder can import the same widths and encodings.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_encoder_8to3_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    // Presentation FSM encoding.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Binary index to one-hot vector.
    function automatic logic [ONEHOT_W-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [ONEHOT_W-1:0] v;
        v = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_encoder_8to3_prio_sel.sv
// ============================================================================
// prio_sel_8to3
// Purely combinational priority selector.
// Ports:
//   vec  in  8  candidate vector
//   idx  out 3  index of the highest-priority set bit (0 when none set)
//   any  out 1  at least one bit of vec is set
// PRIORITY_MSB = 0 : bit 0 wins; PRIORITY_MSB = 1 : bit 7 wins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_sel_8to3
    import irq_encoder_8to3_pkg::*;
#(
    parameter bit PRIORITY_MSB = 1'b0
) (
    input  logic [ONEHOT_W-1:0] vec,
    output logic [CODE_W-1:0]   idx,
    output logic                any
);

    // The scan runs from lowest to highest priority so the last hit,
    // which is the highest-priority set bit, is the one that sticks.
    always_comb begin
        idx = '0;
        any = |vec;
        if (PRIORITY_MSB) begin
            for (int i = 0; i < ONEHOT_W; i++) begin
                if (vec[i]) idx = i[CODE_W-1:0];
            end
        end else begin
            for (int i = ONEHOT_W - 1; i >= 0; i--) begin
                if (vec[i]) idx = i[CODE_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/irq_encoder_8to3.sv
// ============================================================================
// irq_encoder_8to3
// Sequential 8-to-3 request encoder. Requests are latched into a pending
// register; the highest-priority pending request is presented as a 3-bit
// index with a valid/ready handshake, and each accepted index clears its
// pending bit. One index per cycle while ready is held high.
// Ports:
//   clk      in  1  rising-edge clock
//   rst      in  1  asynchronous active-high reset
//   enable   in  1  permits new presentations (does not gate capture)
//   req      in  8  request lines, a 1 sets the pending bit
//   ready    in  1  consumer accepts y when valid && ready
//   y        out 3  presented index (registered)
//   valid    out 1  y is meaningful (registered)
//   pending  out 8  pending register
//   dropped  out 8  one-cycle pulse: request hit an already-pending bit
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_encoder_8to3
    import irq_encoder_8to3_pkg::*;
#(
    parameter bit PRIORITY_MSB = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [ONEHOT_W-1:0] req,
    input  logic                ready,
    output logic [CODE_W-1:0]   y,
    output logic                valid,
    output logic [ONEHOT_W-1:0] pending,
    output logic [ONEHOT_W-1:0] dropped
);

    state_t              state, state_n;
    logic                acc;
    logic [ONEHOT_W-1:0] clr;
    logic [ONEHOT_W-1:0] pending_n;
    logic [ONEHOT_W-1:0] dropped_n;
    logic [CODE_W-1:0]   sel;
    logic                sel_any;
    logic [CODE_W-1:0]   y_n;
    logic                valid_n;

    assign acc = valid & ready;
    assign clr = acc ? onehot(y) : '0;

    // Set wins over clear: an event arriving on the bit being accepted is
    // re-pended rather than lost, and is not reported as dropped.
    assign pending_n = (pending & ~clr) | req;
    assign dropped_n = req & pending & ~clr;

    // Selection looks at the next pending value so a fresh request can be
    // presented on the edge that captures it (1-cycle latency).
    prio_sel_8to3 #(
        .PRIORITY_MSB (PRIORITY_MSB)
    ) u_prio_sel (
        .vec (pending_n),
        .idx (sel),
        .any (sel_any)
    );

    always_comb begin
        state_n = state;
        y_n     = y;
        valid_n = valid;
        case (state)
            ST_IDLE: begin
                if (enable && sel_any) begin
                    state_n = ST_PRESENT;
                    y_n     = sel;
                    valid_n = 1'b1;
                end
            end
            ST_PRESENT: begin
                // Without an accept the index is held: no preemption and
                // no retraction when enable falls.
                if (acc) begin
                    if (enable && sel_any) begin
                        y_n = sel;
                    end else begin
                        state_n = ST_IDLE;
                        valid_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            y       <= '0;
            valid   <= 1'b0;
            pending <= '0;
            dropped <= '0;
        end else begin
            state   <= state_n;
            y       <= y_n;
            valid   <= valid_n;
            pending <= pending_n;
            dropped <= dropped_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_irq_encoder_8to3.sv
// ============================================================================
// tb_irq_encoder_8to3
// Scoreboard bench: two encoders (LSB and MSB priority) share stimulus.
// Expected indices are queued when stimulus is issued; monitors pop and
// compare whenever a DUT completes a handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_encoder_8to3;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] req;
    logic       ready;

    logic [2:0] y0, y1;
    logic       valid0, valid1;
    logic [7:0] pending0, pending1;
    logic [7:0] dropped0, dropped1;

    int tests;
    int fails;

    logic [2:0] q0[$];
    logic [2:0] q1[$];

    irq_encoder_8to3 #(.PRIORITY_MSB(1'b0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .req     (req),
        .ready   (ready),
        .y       (y0),
        .valid   (valid0),
        .pending (pending0),
        .dropped (dropped0)
    );

    irq_encoder_8to3 #(.PRIORITY_MSB(1'b1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .req     (req),
        .ready   (ready),
        .y       (y1),
        .valid   (valid1),
        .pending (pending1),
        .dropped (dropped1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_both(input logic [2:0] a, input logic [2:0] b);
        q0.push_back(a);
        q1.push_back(b);
    endtask

    // Monitors: a handshake is visible at the falling edge and completes on
    // the next rising edge.
    always @(negedge clk) begin
        if (!rst && valid0 && ready) begin
            tests++;
            if (q0.size() == 0) begin
                fails++;
                $display("FAIL mon0_unexpected: got y=%0d expected none", y0);
            end else begin
                logic [2:0] e;
                e = q0.pop_front();
                if (y0 !== e) begin
                    fails++;
                    $display("FAIL mon0_y: got %0d expected %0d at %0t", y0, e, $time);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid1 && ready) begin
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL mon1_unexpected: got y=%0d expected none", y1);
            end else begin
                logic [2:0] e;
                e = q1.pop_front();
                if (y1 !== e) begin
                    fails++;
                    $display("FAIL mon1_y: got %0d expected %0d at %0t", y1, e, $time);
                end
            end
        end
    end

    initial begin
        tests  = 0;
        fails  = 0;
        rst    = 1'b1;
        enable = 1'b1;
        req    = 8'h00;
        ready  = 1'b1;

        // Reset state, then release mid-cycle.
        tick();
        tick();
        check("rst_valid", {7'd0, valid0}, 8'h00);
        check("rst_y", {5'd0, y0}, 8'h00);
        check("rst_pending", pending0, 8'h00);
        check("rst_dropped", dropped0, 8'h00);
        #2 rst = 1'b0;
        tick();

        // Single request, 1-cycle latency.
        push_both(3'd3, 3'd3);
        req = 8'h08;
        tick();
        req = 8'h00;
        check("single_valid", {7'd0, valid0}, 8'h01);
        check("single_y", {5'd0, y0}, 8'h03);
        tick();
        check("single_pending_clr", pending0, 8'h00);
        check("single_valid_clr", {7'd0, valid0}, 8'h00);
        tick();

        // Priority order, back-to-back.
        push_both(3'd0, 3'd7);
        push_both(3'd7, 3'd0);
        req = 8'h81;
        tick();
        req = 8'h00;
        tick();
        tick();
        check("prio_idle", {6'd0, valid1, valid0}, 8'h00);
        tick();

        // Backpressure, no preemption.
        ready = 1'b0;
        push_both(3'd2, 3'd2);
        push_both(3'd0, 3'd0);
        req = 8'h04;
        tick();
        req = 8'h01;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_y", {5'd0, y0}, 8'h02);
            check("bp_hold_valid", {7'd0, valid0}, 8'h01);
            tick();
            req = 8'h00;
        end
        check("bp_pending", pending0, 8'h05);
        ready = 1'b1;
        tick();
        tick();
        tick();

        // Drop and re-pend.
        ready = 1'b0;
        push_both(3'd5, 3'd5);
        push_both(3'd5, 3'd5);
        req = 8'h20;
        tick();
        check("drop_first_none", dropped0, 8'h00);
        tick();
        req = 8'h00;
        check("drop_pulse", dropped0, 8'h20);
        tick();
        check("drop_cleared", dropped0, 8'h00);
        ready = 1'b1;
        req = 8'h20;
        tick();
        req = 8'h00;
        check("repend_valid", {7'd0, valid0}, 8'h01);
        check("repend_y", {5'd0, y0}, 8'h05);
        check("repend_no_drop", dropped0, 8'h00);
        tick();
        tick();

        // Enable gating: capture continues, presentation held off.
        enable = 1'b0;
        req = 8'h12;
        tick();
        req = 8'h00;
        tick();
        check("en_valid_low", {7'd0, valid0}, 8'h00);
        check("en_pending", pending0, 8'h12);
        push_both(3'd1, 3'd4);
        push_both(3'd4, 3'd1);
        enable = 1'b1;
        tick();
        tick();
        tick();
        check("en_drained", pending0, 8'h00);

        // Reset mid-handshake.
        ready = 1'b0;
        req = 8'hF0;
        tick();
        tick();
        req = 8'h00;
        check("pre_rst_valid", {7'd0, valid0}, 8'h01);
        check("pre_rst_pending", pending0, 8'hF0);
        check("pre_rst_dropped", dropped0, 8'hF0);
        #2 rst = 1'b1;
        #1;
        check("async_valid", {6'd0, valid1, valid0}, 8'h00);
        check("async_y", {2'd0, y1, y0}, 8'h00);
        check("async_pending", pending0 | pending1, 8'h00);
        check("async_dropped", dropped0 | dropped1, 8'h00);
        tick();
        rst = 1'b0;
        ready = 1'b1;
        tick();
        tick();

        check("q0_drained", 8'(q0.size()), 8'h00);
        check("q1_drained", 8'(q1.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
